dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_timeout_cnt.sv | 30 +++
 rtl/dmem_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage data controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } dmem_state_e;

   localparam int DEF_TIMEOUT = 255;
   localparam int ALIGN_BIT   = 0;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Access timeout counter: counts cycles while enabled, saturating at TIMEOUT.
module dmem_timeout_cnt
   import dmem_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count;

   // Holding at TIMEOUT keeps hit asserted, so a read accepted on the
   // timeout cycle still aborts if its data never arrives.
   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (en && count != TO_VAL)
         count <= count + CNT_W'(1);
   end

   assign hit = (count == TO_VAL);

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage data controller: single-cycle load/store request to a
// variable-latency memory handshake, with pipeline stall and error pulses.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_wr,
   input  logic [15:0] addr,
   input  logic [15:0] wrdata,
   output logic [15:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic        m_req,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [15:0] m_wdata,
   input  logic        m_ready,
   input  logic        m_rvalid,
   input  logic [15:0] m_rdata
);

   dmem_state_e state;
   logic        misaligned;
   logic        start;
   logic        busy;
   logic        to_hit;

   assign misaligned = addr[ALIGN_BIT];
   assign start      = (state == ST_IDLE) && mem_en && !misaligned;
   assign busy       = (state == ST_REQ) || (state == ST_WAIT);
   assign stall      = start || busy;

   dmem_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (busy),
      .hit (to_hit)
   );

   // Completion is tested before the timeout so a same-cycle response wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         m_req   <= 1'b0;
         m_wr    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_en) begin
                  if (misaligned) begin
                     err <= 1'b1;
                  end else begin
                     state   <= ST_REQ;
                     m_req   <= 1'b1;
                     m_wr    <= mem_wr;
                     m_addr  <= addr;
                     m_wdata <= wrdata;
                  end
               end
            end
            ST_REQ: begin
               if (m_ready) begin
                  m_req <= 1'b0;
                  if (m_wr) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                  end
               end else if (to_hit) begin
                  m_req <= 1'b0;
                  state <= ST_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (m_rvalid) begin
                  rdata <= m_rdata;
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else if (to_hit) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level model builds the expected cycle
// timeline of each access; a negedge process compares every cycle.
module tb_dmem_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en, mem_wr;
   logic [15:0] addr, wrdata;
   logic [15:0] rdata;
   logic        stall, done, err;
   logic        m_req, m_wr;
   logic [15:0] m_addr, m_wdata;
   logic        m_ready, m_rvalid;
   logic [15:0] m_rdata;

   always #5 clk = ~clk;

   dmem_ctrl #(.TIMEOUT(T), .CNT_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_en   (mem_en),
      .mem_wr   (mem_wr),
      .addr     (addr),
      .wrdata   (wrdata),
      .rdata    (rdata),
      .stall    (stall),
      .done     (done),
      .err      (err),
      .m_req    (m_req),
      .m_wr     (m_wr),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_ready  (m_ready),
      .m_rvalid (m_rvalid),
      .m_rdata  (m_rdata)
   );

   int tests = 0;
   int fails = 0;
   int n_stall = 0, n_done = 0, n_req = 0, n_err = 0;
   int s_stall, s_done, s_req, s_err;
   bit chk_en = 1'b0;
   bit err_pend = 1'b0;

   logic        exp_stall = 1'b0, exp_mreq = 1'b0, exp_done = 1'b0;
   logic        exp_err = 1'b0, exp_mwr = 1'b0;
   logic [15:0] exp_rdata = '0, exp_maddr = '0, exp_wdata = '0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ex);
      tests++;
      if (act !== ex) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
      end
   endtask

   // Per-cycle comparison against the model's expectations.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("stall",   16'(stall),  16'(exp_stall));
         chk("m_req",   16'(m_req),  16'(exp_mreq));
         chk("done",    16'(done),   16'(exp_done));
         chk("err",     16'(err),    16'(exp_err));
         chk("m_wr",    16'(m_wr),   16'(exp_mwr));
         chk("rdata",   rdata,       exp_rdata);
         chk("m_addr",  m_addr,      exp_maddr);
         chk("m_wdata", m_wdata,     exp_wdata);
         n_stall += (stall === 1'b1) ? 1 : 0;
         n_done  += (done  === 1'b1) ? 1 : 0;
         n_req   += (m_req === 1'b1) ? 1 : 0;
         n_err   += (err   === 1'b1) ? 1 : 0;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      exp_err  = err_pend;
      err_pend = 1'b0;
      exp_done = 1'b0;
      exp_mreq = 1'b0;
      m_ready  = 1'($urandom);
      m_rvalid = 1'($urandom);
      m_rdata  = 16'($urandom);
   endtask

   task automatic idle_cycle();
      next_cycle();
      mem_en    = 1'b0;
      mem_wr    = 1'($urandom);
      addr      = 16'($urandom);
      wrdata    = 16'($urandom);
      exp_stall = 1'b0;
   endtask

   task automatic misaligned(input logic wr, input logic [15:0] a);
      next_cycle();
      mem_en    = 1'b1;
      mem_wr    = wr;
      addr      = a | 16'h0001;
      wrdata    = 16'($urandom);
      exp_stall = 1'b0;
      err_pend  = 1'b1;
   endtask

   // One aligned access: dr = cycles m_ready is late, dv = cycles m_rvalid
   // is late after acceptance; j is the cycle index within REQ+WAIT.
   task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input int dr, input int dv, input logic [15:0] rd);
      int j;
      bit fin, to, ph;
      next_cycle();
      mem_en    = 1'b1;
      mem_wr    = wr;
      addr      = a;
      wrdata    = wd;
      exp_stall = 1'b1;
      j = 0; fin = 1'b0; to = 1'b0; ph = 1'b0;
      while (!fin) begin
         next_cycle();
         exp_stall = 1'b1;
         exp_mwr   = wr;
         exp_maddr = a;
         exp_wdata = wd;
         if (!ph) begin
            exp_mreq = 1'b1;
            m_ready  = (j == dr);
            if (j == dr) begin
               if (wr) fin = 1'b1;
               else    ph  = 1'b1;
            end else if (j >= T) begin
               fin = 1'b1; to = 1'b1;
            end
         end else begin
            m_rvalid = (j == dr + 1 + dv);
            if (j == dr + 1 + dv) begin
               m_rdata = rd;
               fin = 1'b1;
            end else if (j >= T) begin
               fin = 1'b1; to = 1'b1;
            end
         end
         j++;
      end
      next_cycle();
      exp_stall = 1'b0;
      exp_done  = 1'b1;
      exp_err   = to;
      if (!wr && !to) exp_rdata = rd;
   endtask

   task automatic settle();
      idle_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic snap();
      s_stall = n_stall; s_done = n_done; s_req = n_req; s_err = n_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; addr = '0; wrdata = '0;
      m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      next_cycle();
      mem_en = 1'b0; exp_stall = 1'b0;
      next_cycle();
      rst = 1'b0;
      settle();

      // Aligned load returning 0xBEEF with no extra latency.
      snap();
      access(1'b0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF);
      settle();
      chk("load_stall_cycles", 16'(n_stall - s_stall), 16'd3);
      chk("load_done_pulses",  16'(n_done - s_done),   16'd1);
      chk("load_err_pulses",   16'(n_err - s_err),     16'd0);
      chk("load_rdata",        rdata,                  16'hBEEF);

      // Store with m_ready three cycles late.
      snap();
      access(1'b1, 16'h0020, 16'h1234, 3, 0, 16'h0000);
      settle();
      chk("store_req_cycles",   16'(n_req - s_req),     16'd4);
      chk("store_stall_cycles", 16'(n_stall - s_stall), 16'd5);
      chk("store_done_pulses",  16'(n_done - s_done),   16'd1);
      chk("store_m_addr",       m_addr,                 16'h0020);
      chk("store_m_wdata",      m_wdata,                16'h1234);
      chk("store_m_wr",         16'(m_wr),              16'd1);

      // Misaligned load.
      snap();
      misaligned(1'b0, 16'h0021);
      settle();
      chk("misal_req_cycles",   16'(n_req - s_req),     16'd0);
      chk("misal_stall_cycles", 16'(n_stall - s_stall), 16'd0);
      chk("misal_err_pulses",   16'(n_err - s_err),     16'd1);
      chk("misal_rdata",        rdata,                  16'hBEEF);

      // Timeout: memory never accepts.
      snap();
      access(1'b0, 16'h0030, 16'h0000, 50, 0, 16'h0000);
      settle();
      chk("to_err_pulses",   16'(n_err - s_err),     16'd1);
      chk("to_done_pulses",  16'(n_done - s_done),   16'd1);
      chk("to_stall_cycles", 16'(n_stall - s_stall), 16'd6);
      chk("to_rdata",        rdata,                  16'hBEEF);

      // Acceptance on the timeout cycle itself: no error.
      snap();
      access(1'b1, 16'h0032, 16'hCAFE, T, 0, 16'h0000);
      settle();
      chk("to_edge_err_pulses",  16'(n_err - s_err),     16'd0);
      chk("to_edge_done_pulses", 16'(n_done - s_done),   16'd1);
      chk("to_edge_stall",       16'(n_stall - s_stall), 16'd6);

      // Reset while waiting for read data.
      snap();
      next_cycle();
      mem_en = 1'b1; mem_wr = 1'b0; addr = 16'h0040; wrdata = 16'h7777; exp_stall = 1'b1;
      next_cycle();
      exp_stall = 1'b1; exp_mreq = 1'b1; exp_mwr = 1'b0;
      exp_maddr = 16'h0040; exp_wdata = 16'h7777; m_ready = 1'b1;
      next_cycle();
      exp_stall = 1'b1; m_rvalid = 1'b0;
      next_cycle();
      exp_stall = 1'b1; m_rvalid = 1'b0; rst = 1'b1;
      next_cycle();
      rst = 1'b0; mem_en = 1'b0; exp_stall = 1'b0;
      exp_rdata = '0; exp_maddr = '0; exp_wdata = '0; exp_mwr = 1'b0;
      settle();
      chk("rst_done_pulses", 16'(n_done - s_done), 16'd0);
      chk("rst_err_pulses",  16'(n_err - s_err),   16'd0);
      chk("rst_rdata",       rdata,                16'h0000);
      snap();
      access(1'b0, 16'h0044, 16'h0000, 1, 1, 16'h5A5A);
      settle();
      chk("post_rst_load_rdata", rdata,                  16'h5A5A);
      chk("post_rst_load_stall", 16'(n_stall - s_stall), 16'd5);

      // Back-to-back load then store, mem_en held through DONE.
      snap();
      access(1'b0, 16'h0100, 16'h0000, 0, 0, 16'h0F0F);
      access(1'b1, 16'h0102, 16'hA5A5, 0, 0, 16'h0000);
      settle();
      chk("b2b_done_pulses",  16'(n_done - s_done),   16'd2);
      chk("b2b_req_cycles",   16'(n_req - s_req),     16'd2);
      chk("b2b_stall_cycles", 16'(n_stall - s_stall), 16'd5);
      chk("b2b_rdata",        rdata,                  16'h0F0F);

      // Randomized mix of idle cycles, misaligned and aligned accesses.
      for (int i = 0; i < 250; i++) begin
         int r;
         r = int'($urandom_range(9, 0));
         if (r < 2)
            idle_cycle();
         else if (r == 2)
            misaligned(1'($urandom), 16'($urandom));
         else
            access(1'($urandom), 16'($urandom) & 16'hFFFE, 16'($urandom),
                   int'($urandom_range(6, 0)), int'($urandom_range(5, 0)), 16'($urandom));
      end
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
